l0_skew_ctrl: RTL and testbench
===============================

// Module: l0_skew_ctrl
// PURPOSE
//  Sequencer for the L0 row-FIFO bank feeding the systolic array. On start it
//  streams LEN vectors from activation SRAM into all L0 rows in parallel, then
//  drains the rows with a diagonal skew: row r reads r cycles after row 0.
//  Sits between the core control FSM, the activation SRAM and the L0 bank.
// PARAMETERS
//  ROW   8   number of L0 rows / array rows driven with independent read enables
//  DEPTH 64  L0 FIFO depth; maximum accepted LEN
//  AW    11  SRAM address width
// PORTS
//  clk          in   1          clock, single domain
//  reset        in   1          asynchronous, active-high; forces IDLE
//  start        in   1          begin a load+drain job; sampled in IDLE only
//  base_addr    in   AW         first SRAM address of the job
//  len          in   7          vectors per job, 0..DEPTH
//  array_ready  in   1          array can accept a skewed read this cycle
//  l0_empty     in   ROW        per-row empty flags from L0
//  l0_full      in   1          OR of L0 row full flags
//  sram_cen     out  1          SRAM chip enable, active-low
//  sram_addr    out  AW         SRAM read address
//  l0_wr        out  1          L0 write strobe, all rows
//  l0_rd        out  ROW        per-row L0 read enable
//  busy         out  1          high in any state except IDLE
//  done         out  1          one-cycle pulse at job end
//  err          out  1          sticky protocol error, cleared by reset or start
// BEHAVIOUR
//  Reset values: sram_cen=1, sram_addr=0, l0_wr=0, l0_rd=0, busy=0, done=0,
//   err=0; state=IDLE; counters k=0, t=0.
//  States: IDLE -> LOAD -> FLUSH -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 latches base_addr, len; clears err; next LOAD. If len=0, next
//   DONE directly. len>DEPTH: set err, go DONE, no SRAM/L0 activity.
//  LOAD: registered sram_cen=0, sram_addr=base+k, k=0..len-1, one per cycle;
//   never stalls. After k=len-1 issued, next FLUSH.
//  l0_wr = ~sram_cen delayed one cycle (SRAM latency 1); l0_wr count == len.
//  FLUSH: one cycle so the final SRAM word is written; sram_cen=1; next DRAIN.
//  DRAIN: skew counter t from 0; l0_rd[r] = array_ready & (r <= t < r+len),
//   combinational from t; t increments only when array_ready=1.
//   array_ready=0 -> l0_rd=0 and t holds (whole diagonal freezes, no skew loss).
//   Leave DRAIN when t reaches len+ROW-1 with array_ready=1; next DONE.
//   Each row reads exactly len times; row r first read at t=r.
//  DONE: done=1 for one cycle, busy=1; next IDLE.
//  err set (sticky) if: l0_wr=1 while l0_full=1; any l0_rd[r]=1 while
//   l0_empty[r]=1; len>DEPTH at start. err never alters sequencing.
//  start while busy: ignored, no effect on current job.
//  Address arithmetic: base+k modulo 2^AW (wraps silently).
//  Mid-job reset: immediate return to reset values; in-flight SRAM read dropped.
//  Throughput: job of len vectors takes 1+len+1+(len+ROW-1)+1 cycles w/o stalls.
// TESTING
//  len=4, base=0x010, ready=1 -> addr 0x010..0x013, 4 l0_wr one cycle late,
//   row0 reads t=0..3, row7 t=7..10, done 17 cycles after start, err=0.
//  len=4, array_ready low for 3 cycles at t=2 -> t holds at 2, l0_rd=0 during
//   stall, each row still 4 reads, done delayed exactly 3 cycles.
//  len=0 -> IDLE,DONE,IDLE; no sram_cen/l0_wr/l0_rd activity; done pulse once.
//  len=64 then start pulsed mid-DRAIN -> 64 writes, 64 reads per row, second
//   start ignored, err=0; len=65 -> err=1, done, no writes.
//  reset asserted mid-DRAIN (async, between edges) -> outputs at reset values
//   same cycle; new start afterwards runs clean job.
//  Force l0_empty[3]=1 during row-3 read window -> err=1 sticky until next start.

Source files
------------

// File: rtl/l0_skew_ctrl.sv
// l0_skew_ctrl: loads LEN activation vectors from SRAM into every L0 row in
// parallel, then drains the rows with a diagonal skew (row r starts r cycles
// after row 0). The diagonal freezes as a whole when the array is not ready.
module l0_skew_ctrl #(
  parameter int ROW   = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [6:0]    len,
  input  logic          array_ready,
  input  logic [ROW-1:0] l0_empty,
  input  logic          l0_full,
  output logic          sram_cen,
  output logic [AW-1:0] sram_addr,
  output logic          l0_wr,
  output logic [ROW-1:0] l0_rd,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [7:0] DEPTH_W = 8'(DEPTH);
  // Last skew value that still carries a read: row ROW-1 reading its final vector.
  localparam logic [7:0] T_TAIL  = 8'(ROW - 2);

  state_t        state_q, state_d;
  logic [6:0]    len_q, len_d;
  logic [6:0]    k_q, k_d;
  logic [7:0]    t_q, t_d;
  logic          cen_q, cen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;

  logic [7:0]    t_last;
  logic [ROW-1:0] rd_win;

  assign t_last = {1'b0, len_q} + T_TAIL;

  // Per-row read window: row gi is active for skew values gi .. gi+len-1.
  genvar gi;
  generate
    for (gi = 0; gi < ROW; gi++) begin : g_rd_win
      assign rd_win[gi] = (t_q >= 8'(gi)) && (t_q < (8'(gi) + {1'b0, len_q}));
    end
  endgenerate

  // Reads are combinational from the skew counter so a not-ready cycle drops them at once.
  assign l0_rd = ((state_q == S_DRAIN) && array_ready) ? rd_win : '0;

  // Next-state, counters and registered SRAM/L0 strobes.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    k_d     = k_q;
    t_d     = t_q;
    cen_d   = 1'b1;
    addr_d  = addr_q;
    // SRAM has one cycle of read latency, so the L0 write trails the enable.
    wr_d    = ~cen_q;
    err_d   = err_q | (wr_q & l0_full) | (|(l0_rd & l0_empty));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = len;
          k_d   = '0;
          t_d   = '0;
          err_d = ({1'b0, len} > DEPTH_W);
          if (({1'b0, len} > DEPTH_W) || (len == 7'd0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            cen_d   = 1'b0;
            addr_d  = base_addr;
          end
        end
      end
      S_LOAD: begin
        if (k_q == (len_q - 7'd1)) begin
          state_d = S_FLUSH;
        end else begin
          cen_d  = 1'b0;
          k_d    = k_q + 7'd1;
          // Address wraps modulo 2^AW by construction.
          addr_d = addr_q + AW'(1);
        end
      end
      S_FLUSH: begin
        state_d = S_DRAIN;
        t_d     = '0;
      end
      S_DRAIN: begin
        if (array_ready) begin
          t_d = t_q + 8'd1;
          if (t_q == t_last) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns everything to idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      k_q     <= '0;
      t_q     <= '0;
      cen_q   <= 1'b1;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      k_q     <= k_d;
      t_q     <= t_d;
      cen_q   <= cen_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  assign sram_cen  = cen_q;
  assign sram_addr = addr_q;
  assign l0_wr     = wr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_l0_skew_ctrl.sv
// Directed bench for l0_skew_ctrl: expected SRAM addresses and done cycles
// are queued when a job is launched and consumed as the DUT produces them.
module tb_l0_skew_ctrl;
  localparam int ROW = 8;
  localparam int AW  = 11;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic [6:0]     len = '0;
  logic           array_ready = 1'b1;
  logic [ROW-1:0] l0_empty = '0;
  logic           l0_full = 1'b0;
  logic           sram_cen;
  logic [AW-1:0]  sram_addr;
  logic           l0_wr;
  logic [ROW-1:0] l0_rd;
  logic           busy;
  logic           done;
  logic           err;

  always #5 clk = ~clk;

  l0_skew_ctrl #(.ROW(ROW), .DEPTH(64), .AW(AW)) dut (
    .clk(clk), .reset(rst), .start(start), .base_addr(base_addr), .len(len),
    .array_ready(array_ready), .l0_empty(l0_empty), .l0_full(l0_full),
    .sram_cen(sram_cen), .sram_addr(sram_addr), .l0_wr(l0_wr), .l0_rd(l0_rd),
    .busy(busy), .done(done), .err(err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [AW-1:0] addr_q[$];
  int            done_q[$];

  int   wr_cnt, first_wr, busy_cnt, done_cnt;
  int   rd_cnt[ROW];
  int   first_rd[ROW];
  int   last_rd[ROW];
  logic busy_s, err_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0; first_wr = -1; busy_cnt = 0; done_cnt = 0;
    for (int r = 0; r < ROW; r++) begin
      rd_cnt[r] = 0; first_rd[r] = -1; last_rd[r] = -1;
    end
  endtask

  // Observe one cycle of DUT outputs; consumes scoreboard entries.
  task automatic sample();
    logic [AW-1:0] ea;
    int ed;
    busy_s = busy;
    err_s  = err;
    if (busy) busy_cnt++;
    if (!sram_cen) begin
      chk("sram_read_expected", (addr_q.size() > 0), 1);
      if (addr_q.size() > 0) begin
        ea = addr_q.pop_front();
        chk("sram_addr", sram_addr, ea);
      end
    end
    if (l0_wr) begin
      wr_cnt++;
      if (wr_cnt == 1) first_wr = cyc;
    end
    for (int r = 0; r < ROW; r++) begin
      if (l0_rd[r]) begin
        rd_cnt[r]++;
        if (rd_cnt[r] == 1) first_rd[r] = cyc;
        last_rd[r] = cyc;
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_expected", (done_q.size() > 0), 1);
      if (done_q.size() > 0) begin
        ed = done_q.pop_front();
        chk("done_cycle", cyc, ed);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_sram_cen"}, sram_cen, 1);
    chk({pfx, "_sram_addr"}, sram_addr, 0);
    chk({pfx, "_l0_wr"}, l0_wr, 0);
    chk({pfx, "_l0_rd"}, l0_rd, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_err"}, err, 0);
  endtask

  // Launch one job, optionally stall the array and pulse a stray start,
  // then check counts, read windows and timing against the expected skew.
  task automatic run_job(input logic [AW-1:0] base, input int len_v, input int stall_t,
                         input int stall_n, input int mid_rel, input logic exp_err);
    int s, off, len_eff, rel, d, tf, tl;
    logic [AW-1:0] a;
    len_eff = (len_v <= 64) ? len_v : 0;
    off = (len_eff == 0) ? 1 : (2 * len_eff + ROW + 1 + stall_n);
    s = cyc;
    a = base;
    for (int i = 0; i < len_eff; i++) begin
      addr_q.push_back(a);
      a = a + AW'(1);
    end
    done_q.push_back(s + off);
    clear_stats();
    start = 1'b1; base_addr = base; len = 7'(len_v); array_ready = 1'b1;
    step();
    for (int i = 0; i < off + 20 && done_cnt == 0; i++) begin
      rel = cyc - s;
      d = rel - (len_eff + 2);
      array_ready = !(stall_n > 0 && d >= stall_t && d < stall_t + stall_n);
      if (mid_rel > 0 && rel == mid_rel) begin
        start = 1'b1; base_addr = 11'h400; len = 7'd5;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0; array_ready = 1'b1;
    step();
    $display("job base=%0h len=%0d stall=%0d@%0d: writes=%0d done_cnt=%0d err=%0d",
             base, len_v, stall_n, stall_t, wr_cnt, done_cnt, err_s);
    chk("done_count", done_cnt, 1);
    chk("busy_after_done", busy_s, 0);
    chk("err_after_job", err_s, exp_err);
    chk("write_count", wr_cnt, len_eff);
    chk("busy_cycles", busy_cnt, off);
    chk("addr_left", addr_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    if (len_eff > 0) begin
      chk("first_write_cycle", first_wr, s + 2);
      for (int r = 0; r < ROW; r++) begin
        tf = r;
        tl = r + len_eff - 1;
        if (stall_n > 0 && tf >= stall_t) tf += stall_n;
        if (stall_n > 0 && tl >= stall_t) tl += stall_n;
        chk($sformatf("rd_count_row%0d", r), rd_cnt[r], len_eff);
        chk($sformatf("first_rd_row%0d", r), first_rd[r], s + len_eff + 2 + tf);
        chk($sformatf("last_rd_row%0d", r), last_rd[r], s + len_eff + 2 + tl);
      end
    end else begin
      for (int r = 0; r < ROW; r++) chk($sformatf("rd_none_row%0d", r), rd_cnt[r], 0);
    end
  endtask

  initial begin
    int s;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst = 1'b0;
    cyc = 0;
    step();

    run_job(11'h010, 4, 0, 0, 0, 1'b0);
    run_job(11'h020, 4, 2, 3, 0, 1'b0);
    run_job(11'h030, 0, 0, 0, 0, 1'b0);
    run_job(11'h100, 64, 0, 0, 76, 1'b0);
    run_job(11'h200, 65, 0, 0, 0, 1'b1);
    run_job(11'h7FE, 4, 0, 0, 0, 1'b0);

    // Row 3 reported empty across its read window.
    l0_empty = 8'h08;
    run_job(11'h040, 4, 0, 0, 0, 1'b1);
    l0_empty = '0;
    repeat (3) step();
    chk("err_sticky", err_s, 1);

    // L0 reported full while loading.
    l0_full = 1'b1;
    run_job(11'h050, 3, 0, 0, 0, 1'b1);
    l0_full = 1'b0;

    // Asynchronous reset in the middle of DRAIN.
    s = cyc;
    clear_stats();
    for (int i = 0; i < 8; i++) addr_q.push_back(11'h060 + AW'(i));
    start = 1'b1; base_addr = 11'h060; len = 7'd8;
    step();
    start = 1'b0;
    while (cyc < s + 14) step();
    chk("rd_active_before_reset", (l0_rd != '0), 1);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset asserted mid-drain at cycle %0d", cyc);
    chk_reset_outs("midreset");
    addr_q.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    step();
    chk("busy_after_reset", busy_s, 0);

    run_job(11'h070, 4, 0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
